// File: rtl/plab3_mem_domain_mem_guard_pkg.sv
// Shared constants for the domain-aware memory guard: FSM states, message
// field widths and the default secure address window.
package plab3_mem_domain_mem_guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FWD  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_DENY = 3'd4
  } state_e;

  localparam int TYPE_NBITS = 3;
  localparam int TEST_NBITS = 2;

  localparam logic [31:0] SEC_BASE_DEFAULT  = 32'h0000_8000;
  localparam logic [31:0] SEC_LIMIT_DEFAULT = 32'h0000_FFFF;

  // Length field counts bytes within a line; zero means a full line.
  function automatic int len_nbits(input int d);
    return $clog2(d / 8);
  endfunction

  // Request layout, MSB first: type | opaque | addr | len | data
  function automatic int req_nbits(input int o, input int a, input int d);
    return TYPE_NBITS + o + a + len_nbits(d) + d;
  endfunction

  // Response layout, MSB first: type | opaque | test | len | data
  function automatic int resp_nbits(input int o, input int d);
    return TYPE_NBITS + o + TEST_NBITS + len_nbits(d) + d;
  endfunction

endpackage

// File: rtl/plab3_mem_domain_range_check.sv
// Combinational deny decision: a non-secure request whose address falls
// inside the secure window is refused.
module plab3_mem_domain_range_check
  import plab3_mem_domain_mem_guard_pkg::*;
#(
  parameter int                      p_addr_nbits = 32,
  parameter logic [p_addr_nbits-1:0] p_sec_base   = p_addr_nbits'(SEC_BASE_DEFAULT),
  parameter logic [p_addr_nbits-1:0] p_sec_limit  = p_addr_nbits'(SEC_LIMIT_DEFAULT)
) (
  input  logic [p_addr_nbits-1:0] addr_i,
  input  logic                    domain_i,
  output logic                    deny_o
);

  assign deny_o = domain_i && (addr_i >= p_sec_base) && (addr_i <= p_sec_limit);

endmodule

// File: rtl/plab3_mem_domain_mem_guard.sv
// Blocking memory-port guard: buffers one cache line request, forwards it to
// memory or answers it locally with a fault when it violates the secure window.
module plab3_mem_domain_mem_guard
  import plab3_mem_domain_mem_guard_pkg::*;
#(
  parameter int                      p_opaque_nbits = 8,
  parameter int                      p_addr_nbits   = 32,
  parameter int                      p_data_nbits   = 128,
  parameter logic [p_addr_nbits-1:0] p_sec_base     = p_addr_nbits'(SEC_BASE_DEFAULT),
  parameter logic [p_addr_nbits-1:0] p_sec_limit    = p_addr_nbits'(SEC_LIMIT_DEFAULT)
) (
  input  logic                                                          clk,
  input  logic                                                          reset,
  input  logic                                                          memreq_val,
  output logic                                                          memreq_rdy,
  input  logic [req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] memreq_msg,
  input  logic                                                          memreq_domain,
  output logic                                                          memresp_val,
  input  logic                                                          memresp_rdy,
  output logic [resp_nbits(p_opaque_nbits, p_data_nbits)-1:0]           memresp_msg,
  output logic                                                          memresp_domain,
  output logic                                                          mreq_val,
  input  logic                                                          mreq_rdy,
  output logic [req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] mreq_msg,
  input  logic                                                          mresp_val,
  output logic                                                          mresp_rdy,
  input  logic [resp_nbits(p_opaque_nbits, p_data_nbits)-1:0]           mresp_msg,
  output logic                                                          fault,
  output logic [7:0]                                                    fault_count
);

  localparam int O  = p_opaque_nbits;
  localparam int A  = p_addr_nbits;
  localparam int D  = p_data_nbits;
  localparam int LN = len_nbits(D);
  localparam int RQ = req_nbits(O, A, D);
  localparam int RS = resp_nbits(O, D);

  state_e          state_q;
  logic [RQ-1:0]   req_q;
  logic            domain_q;
  logic [RS-1:0]   resp_q;
  logic            fault_q;
  logic [7:0]      fault_count_q;

  logic [TYPE_NBITS-1:0] in_type;
  logic [O-1:0]          in_opaque;
  logic [A-1:0]          in_addr;
  logic                  deny;

  assign in_type   = memreq_msg[D+LN+A+O +: TYPE_NBITS];
  assign in_opaque = memreq_msg[D+LN+A +: O];
  assign in_addr   = memreq_msg[D+LN +: A];

  plab3_mem_domain_range_check #(
    .p_addr_nbits (A),
    .p_sec_base   (p_sec_base),
    .p_sec_limit  (p_sec_limit)
  ) u_range_check (
    .addr_i   (in_addr),
    .domain_i (memreq_domain),
    .deny_o   (deny)
  );

  // The denial response is built into the response register at capture time,
  // so memresp_msg always comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      domain_q      <= 1'b0;
      resp_q        <= '0;
      fault_q       <= 1'b0;
      fault_count_q <= 8'd0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (memreq_val) begin
            req_q    <= memreq_msg;
            domain_q <= memreq_domain;
            if (deny) begin
              state_q <= ST_DENY;
              fault_q <= 1'b1;
              resp_q  <= {in_type, in_opaque, {TEST_NBITS{1'b0}}, {LN{1'b0}}, {D{1'b0}}};
              if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
            end else begin
              state_q <= ST_FWD;
            end
          end
        end
        ST_FWD: if (mreq_rdy) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mresp_val) begin
            resp_q  <= mresp_msg;
            state_q <= ST_RESP;
          end
        end
        ST_RESP, ST_DENY: if (memresp_rdy) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign memreq_rdy     = (state_q == ST_IDLE);
  assign mreq_val       = (state_q == ST_FWD);
  assign mreq_msg       = req_q;
  assign mresp_rdy      = (state_q == ST_WAIT);
  assign memresp_val    = (state_q == ST_RESP) || (state_q == ST_DENY);
  assign memresp_msg    = resp_q;
  assign memresp_domain = domain_q;
  assign fault          = fault_q;
  assign fault_count    = fault_count_q;

endmodule

// File: doc/plab3_mem_domain_mem_guard.md
# plab3_mem_domain_mem_guard

Domain-aware memory-port guard between the NS-bit blocking cache's refill/evict port and main memory. Each cache-line memory request, tagged with the cache's domain bit, is buffered and checked against a fixed secure address window. Permitted requests go to memory and the response returns to the cache. Non-secure requests into the window are answered locally without a memory access, and a fault is logged. The block is blocking: at most one transaction is in flight.

## Interface
Parameters:
- p_opaque_nbits, 8, opaque field width
- p_addr_nbits, 32, address width
- p_data_nbits, 128, data width (one cache line)
- p_sec_base, 32'h0000_8000, first byte address of the secure window (line aligned)
- p_sec_limit, 32'h0000_FFFF, last byte address of the secure window (inclusive)

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- memreq_val  in  1  cache-side request valid
- memreq_rdy  out  1  cache-side request ready
- memreq_msg  in  VC_MEM_REQ_MSG_NBITS(o,a,d)  line request from the cache
- memreq_domain  in  1  request domain; 1 = non-secure, 0 = secure
- memresp_val  out  1  cache-side response valid
- memresp_rdy  in  1  cache-side response ready
- memresp_msg  out  VC_MEM_RESP_MSG_NBITS(o,d)  response to the cache
- memresp_domain  out  1  domain of the transaction being answered
- mreq_val / mreq_rdy  out / in  1  memory-side request handshake
- mreq_msg  out  VC_MEM_REQ_MSG_NBITS(o,a,d)  forwarded request, bit-identical to the accepted request
- mresp_val / mresp_rdy  in / out  1  memory-side response handshake
- mresp_msg  in  VC_MEM_RESP_MSG_NBITS(o,d)  memory response
- fault  out  1  one-cycle pulse when a request is denied
- fault_count  out  8  saturating count of denied requests

## Operation
- FSM states: IDLE, FWD, WAIT, RESP, DENY.
- IDLE
  - memreq_rdy=1.
  - On a fire: capture msg and domain into the request register.
  - Deny condition: domain==1 && p_sec_base <= addr <= p_sec_limit (unsigned compare on the full address).
  - Denied: go to DENY, pulse fault, increment fault_count (saturates at 255).
  - Otherwise: go to FWD.
- FWD
  - mreq_val=1, mreq_msg = request register.
  - Stay until mreq_rdy, then go to WAIT.
- WAIT
  - mresp_rdy=1.
  - On mresp_val: capture mresp_msg into the response register, go to RESP.
- RESP
  - memresp_val=1 with the captured response.
  - On memresp_rdy: go to IDLE.
- DENY: memresp_val=1 with a locally built response, then go to IDLE on memresp_rdy.
  - Response fields: type = request type, opaque = request opaque, len = 0, data = 0.
  - Write requests are dropped; the zero-data response acts as the acknowledgement.
- memresp_domain always equals the registered request domain.
- mresp_rdy=0 outside WAIT; a memory response arriving in any other state is not consumed.
- memreq_rdy=0 outside IDLE. No new request is accepted in the cycle a response is delivered.

## Timing
- Reset values: FSM = IDLE; all val outputs = 0; fault = 0; fault_count = 0; request and response registers = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the in-flight transaction is abandoned with no response. fault_count clears.
- Permitted path, minimum latency:
  - request fires in cycle 0;
  - mreq_val is high in cycle 1;
  - memory response captured in cycle k ≥ 2;
  - memresp_val is high in cycle k+1.
- Denied path: memresp_val high in cycle 1; fault high in cycle 1 only.
- All outputs are driven from registers or from the state decode. There are no combinational paths from input val/rdy signals to output val/rdy signals.
- Back-pressure: a message is held stable while its val is high and its rdy is low.

## Structure
- State encodings and the secure-window defaults go in a shared constants include, alongside the vc-mem-msgs macros.
- Message fields are handled with vc_MemReqMsgUnpack and vc_MemRespMsgPack.
- Storage uses vc_EnResetReg and vc_ResetReg.
- One sub-module: plab3_mem_domain_range_check, a combinational check of address and domain that produces the deny signal.

## Test plan
- Secure read, addr 0x8000, domain 0 -> forwarded unchanged; memory returns data 0xDEADBEEF…; cache sees that data with the original opaque; fault_count = 0.
- Non-secure read, addr 0x8010, domain 1 -> no mreq_val; memresp_val in cycle 1 with data 0; fault pulse; fault_count = 1.
- Non-secure write at the boundaries:
  - 0x7FF0 -> forwarded;
  - 0x10000 -> forwarded;
  - 0xFFF0 -> denied with a write ack.
- Back-pressure: mreq_rdy low for 3 cycles and memresp_rdy low for 2 cycles -> mreq_msg and memresp_msg hold stable; memreq_rdy stays 0 until delivery.
- 256 denied requests -> fault_count saturates at 255.
- Reset asserted while in WAIT -> all outputs at reset values next edge; a new request is accepted after reset deasserts.
